if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
- Front-end fetch sequencer for the 32-bit LoongArch core.
- Owns the fetch PC and issues one outstanding instruction-cache request at a time.
- Drops responses made stale by redirects, then drives the PC, valid, stall and clear inputs of the IF0->IF1 pipeline register.
- Sits between the iCache request/response ports and the IF0/IF1 boundary; takes redirects from EX (branch), WB/CSR (exception, ertn) and stall from ID.

Parameters:
- PC_RST, 32'h1C00_0000, fetch PC after reset.
- WORD, 32, address/PC width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- id_stall  in  1  downstream (ID) cannot accept; hold IF0->IF1.
- br_valid  in  1  branch redirect from EX.
- br_target  in  WORD  branch target.
- excp_valid  in  1  exception flush.
- excp_entry  in  WORD  exception entry PC.
- ertn_valid  in  1  ertn return.
- ertn_era  in  WORD  return PC.
- ic_req_valid  out  1  fetch request to iCache.
- ic_req_addr  out  WORD  request address.
- ic_req_ready  in  1  iCache accepts request.
- ic_rsp_valid  in  1  iCache data returned.
- ic_rsp_ready  out  1  controller accepts data.
- fetch_pc  out  WORD  PC presented to IF0->IF1 (IF0_IF1_PC_in).
- fetch_valid  out  1  forwarded response valid (becomes IF1 iCache_valid).
- if0_if1_stall  out  1  hold IF0->IF1.
- if0_if1_clear  out  1  flush IF0->IF1.

Behaviour:
- Registers:
  - pc_r: next fetch PC.
  - req_pc: PC of the in-flight request.
  - state: RUN, WAIT, DROP.
- Reset: pc_r=PC_RST, req_pc=PC_RST, state=RUN. All outputs 0 except ic_req_addr=PC_RST and fetch_pc=PC_RST.
- redirect = excp_valid|ertn_valid|br_valid. Target priority: excp_entry > ertn_era > br_target. Target bits [1:0] are forced to 0.
- if0_if1_clear = redirect (combinational, same cycle).
- if0_if1_stall = id_stall & ~redirect.
- RUN:
  - ic_req_valid = ~redirect; ic_req_addr = pc_r; ic_rsp_ready = 0.
  - redirect: pc_r <= target; stay RUN (request issued next cycle).
  - Else on ic_req_valid & ic_req_ready: req_pc <= pc_r, pc_r <= pc_r+4 (32-bit wrap), ->WAIT.
- WAIT:
  - ic_req_valid = 0; ic_rsp_ready = ~id_stall | redirect.
  - ic_rsp_valid & ~redirect & ~id_stall: fetch_valid=1, fetch_pc=req_pc, ->RUN.
  - ic_rsp_valid & redirect (same cycle): response consumed and discarded, fetch_valid=0, pc_r <= target, ->RUN.
  - redirect without response: pc_r <= target, ->DROP.
  - ic_rsp_valid & id_stall & ~redirect: not accepted; stay WAIT; iCache must hold the response.
- DROP:
  - ic_req_valid = 0; ic_rsp_ready = 1; fetch_valid = 0.
  - Further redirects overwrite pc_r (latest wins, with priority applied within a cycle).
  - On ic_rsp_valid: ->RUN.
- fetch_valid is asserted only in the WAIT forward case. fetch_pc = req_pc at all times.
- At most one request outstanding. A new request issues in the cycle after the forward, so peak throughput is 1 instruction per 2 cycles with a 1-cycle-latency cache.
- rst mid-operation: return to RUN/PC_RST immediately. Any in-flight iCache response is the iCache's responsibility (the iCache is reset by the same rst).

Decomposition:
- Shared package/header: WORD, PC_RST, state encoding (RUN=2'd0, WAIT=2'd1, DROP=2'd2), ERA/entry width constants.
- One natural sub-module: if_redirect_mux, a combinational priority select of redirect/target plus low-bit masking.
- FSM and PC registers stay in if_fetch_ctrl.

Test Plan:
- Reset, ic_req_ready=1, 1-cycle rsp, id_stall=0: requests at 0x1C000000, 0x1C000004, 0x1C000008; fetch_valid pulses with matching fetch_pc every 2nd cycle.
- br_valid with br_target=0x1C000100 while in RUN: if0_if1_clear=1 that cycle, ic_req_valid=0, next request addr=0x1C000100.
- Redirect to 0x1C000200 while in WAIT, rsp 3 cycles later: ->DROP; response accepted but fetch_valid=0; next request 0x1C000200.
- excp_valid (entry 0x1C008000) and br_valid (0x1C000300) together: next request 0x1C008000.
- id_stall=1 while rsp_valid in WAIT: ic_rsp_ready=0, if0_if1_stall=1, state held; on release the response is forwarded with fetch_pc unchanged.
- rst asserted in DROP: next cycle state RUN, request addr 0x1C000000; br_target 0x1C000103 yields addr 0x1C000100.

Source files
------------

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared constants, state encoding and redirect payload for the IF0 fetch sequencer.
package if_fetch_ctrl_pkg;

  localparam int unsigned WORD    = 32;
  localparam int unsigned ERA_W   = WORD;
  localparam int unsigned ENTRY_W = WORD;

  localparam logic [WORD-1:0] PC_RST  = 32'h1C00_0000;
  localparam logic [WORD-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [WORD-1:0] target;
  } redirect_t;

  // Instructions are word aligned; low address bits of any redirect are discarded.
  function automatic logic [WORD-1:0] align_word(input logic [WORD-1:0] pc);
    return {pc[WORD-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_redirect_mux.sv
// Priority select of the fetch redirect source: exception > ertn > branch.
module if_redirect_mux
  import if_fetch_ctrl_pkg::*;
(
  input  logic               excp_valid_i,
  input  logic [ENTRY_W-1:0] excp_entry_i,
  input  logic               ertn_valid_i,
  input  logic [ERA_W-1:0]   ertn_era_i,
  input  logic               br_valid_i,
  input  logic [WORD-1:0]    br_target_i,
  output redirect_t          redirect_o
);

  always_comb begin
    redirect_o = '0;
    if (excp_valid_i) begin
      redirect_o.valid  = 1'b1;
      redirect_o.target = align_word(WORD'(excp_entry_i));
    end else if (ertn_valid_i) begin
      redirect_o.valid  = 1'b1;
      redirect_o.target = align_word(WORD'(ertn_era_i));
    end else if (br_valid_i) begin
      redirect_o.valid  = 1'b1;
      redirect_o.target = align_word(br_target_i);
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF0 fetch sequencer: owns the fetch PC, keeps one iCache request in flight,
// discards responses made stale by redirects and drives the IF0->IF1 register.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               id_stall,
  input  logic               br_valid,
  input  logic [WORD-1:0]    br_target,
  input  logic               excp_valid,
  input  logic [ENTRY_W-1:0] excp_entry,
  input  logic               ertn_valid,
  input  logic [ERA_W-1:0]   ertn_era,
  output logic               ic_req_valid,
  output logic [WORD-1:0]    ic_req_addr,
  input  logic               ic_req_ready,
  input  logic               ic_rsp_valid,
  output logic               ic_rsp_ready,
  output logic [WORD-1:0]    fetch_pc,
  output logic               fetch_valid,
  output logic               if0_if1_stall,
  output logic               if0_if1_clear
);

  fetch_state_e    state_q, state_d;
  logic [WORD-1:0] pc_q, pc_d;
  logic [WORD-1:0] req_pc_q, req_pc_d;
  redirect_t       redir;

  if_redirect_mux u_redirect_mux (
    .excp_valid_i (excp_valid),
    .excp_entry_i (excp_entry),
    .ertn_valid_i (ertn_valid),
    .ertn_era_i   (ertn_era),
    .br_valid_i   (br_valid),
    .br_target_i  (br_target),
    .redirect_o   (redir)
  );

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= PC_RST;
      req_pc_q <= PC_RST;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Next state and handshake outputs; the IF0->IF1 controls react in the same cycle.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    ic_req_valid  = 1'b0;
    ic_rsp_ready  = 1'b0;
    fetch_valid   = 1'b0;
    if0_if1_clear = redir.valid;
    if0_if1_stall = id_stall & ~redir.valid;

    unique case (state_q)
      ST_RUN: begin
        ic_req_valid = ~redir.valid;
        if (redir.valid) begin
          pc_d = redir.target;
        end else if (ic_req_ready) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_STEP;
          state_d  = ST_WAIT;
        end
      end

      ST_WAIT: begin
        ic_rsp_ready = ~id_stall | redir.valid;
        if (redir.valid) begin
          // A response arriving with the redirect is consumed and dropped here.
          pc_d    = redir.target;
          state_d = ic_rsp_valid ? ST_RUN : ST_DROP;
        end else if (ic_rsp_valid && !id_stall) begin
          fetch_valid = 1'b1;
          state_d     = ST_RUN;
        end
      end

      ST_DROP: begin
        ic_rsp_ready = 1'b1;
        if (redir.valid) begin
          pc_d = redir.target;
        end
        if (ic_rsp_valid) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (rst) begin
      ic_req_valid  = 1'b0;
      ic_rsp_ready  = 1'b0;
      fetch_valid   = 1'b0;
      if0_if1_clear = 1'b0;
      if0_if1_stall = 1'b0;
    end
  end

  assign ic_req_addr = pc_q;
  assign fetch_pc    = req_pc_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with an iCache responder and a per-cycle reference model.
module tb_if_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        id_stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        excp_valid;
  logic [31:0] excp_entry;
  logic        ertn_valid;
  logic [31:0] ertn_era;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_req_ready;
  logic        ic_rsp_valid;
  logic        ic_rsp_ready;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic        if0_if1_stall;
  logic        if0_if1_clear;

  int n_checks = 0;
  int n_fail   = 0;

  // iCache responder state
  int lat  = 1;
  bit pend = 1'b0;
  int cd   = 0;

  // Reference model: next PC, in-flight PC, request outstanding, outstanding request is stale
  logic [31:0] m_pc;
  logic [31:0] m_req_pc;
  bit          m_busy;
  bit          m_stale;
  bit          m_redir;
  logic [31:0] m_tgt;

  if_fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .id_stall      (id_stall),
    .br_valid      (br_valid),
    .br_target     (br_target),
    .excp_valid    (excp_valid),
    .excp_entry    (excp_entry),
    .ertn_valid    (ertn_valid),
    .ertn_era      (ertn_era),
    .ic_req_valid  (ic_req_valid),
    .ic_req_addr   (ic_req_addr),
    .ic_req_ready  (ic_req_ready),
    .ic_rsp_valid  (ic_rsp_valid),
    .ic_rsp_ready  (ic_rsp_ready),
    .fetch_pc      (fetch_pc),
    .fetch_valid   (fetch_valid),
    .if0_if1_stall (if0_if1_stall),
    .if0_if1_clear (if0_if1_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Advance one cycle; the responder holds its data until accepted.
  task automatic step();
    bit rq, rs, rr;
    @(negedge clk); #1;
    rq = ic_req_valid & ic_req_ready;
    rs = ic_rsp_valid & ic_rsp_ready;
    rr = rst;
    @(posedge clk); #1;
    if (rr) begin
      pend = 1'b0;
      ic_rsp_valid = 1'b0;
    end else begin
      if (rs) begin
        ic_rsp_valid = 1'b0;
        pend = 1'b0;
      end
      if (rq) begin
        pend = 1'b1;
        cd = lat;
      end
      if (pend && !ic_rsp_valid) begin
        if (cd <= 1) ic_rsp_valid = 1'b1;
        else cd--;
      end
    end
  endtask

  // Per-cycle comparison against the model, then advance the model.
  always @(negedge clk) begin
    if (rst) begin
      chk1("m_rst_req_valid", ic_req_valid, 1'b0);
      chk1("m_rst_rsp_ready", ic_rsp_ready, 1'b0);
      chk1("m_rst_fetch_valid", fetch_valid, 1'b0);
      chk1("m_rst_clear", if0_if1_clear, 1'b0);
      chk1("m_rst_stall", if0_if1_stall, 1'b0);
      m_pc = 32'h1C00_0000;
      m_req_pc = 32'h1C00_0000;
      m_busy = 1'b0;
      m_stale = 1'b0;
    end else begin
      m_redir = excp_valid | ertn_valid | br_valid;
      if (excp_valid)      m_tgt = excp_entry;
      else if (ertn_valid) m_tgt = ertn_era;
      else                 m_tgt = br_target;
      m_tgt = m_tgt & 32'hFFFF_FFFC;

      chk32("m_req_addr", ic_req_addr, m_pc);
      chk32("m_fetch_pc", fetch_pc, m_req_pc);
      chk1("m_clear", if0_if1_clear, m_redir);
      chk1("m_stall", if0_if1_stall, id_stall & ~m_redir);
      chk1("m_req_valid", ic_req_valid, !m_busy && !m_redir);
      if (!m_busy) chk1("m_rsp_ready", ic_rsp_ready, 1'b0);
      else if (m_stale) chk1("m_rsp_ready", ic_rsp_ready, 1'b1);
      else chk1("m_rsp_ready", ic_rsp_ready, !id_stall || m_redir);
      chk1("m_fetch_valid", fetch_valid,
           m_busy && !m_stale && ic_rsp_valid && !m_redir && !id_stall);

      if (!m_busy) begin
        if (m_redir) m_pc = m_tgt;
        else if (ic_req_ready) begin
          m_req_pc = m_pc;
          m_pc = m_pc + 32'd4;
          m_busy = 1'b1;
          m_stale = 1'b0;
        end
      end else if (!m_stale) begin
        if (m_redir) begin
          m_pc = m_tgt;
          if (ic_rsp_valid) m_busy = 1'b0;
          else m_stale = 1'b1;
        end else if (ic_rsp_valid && !id_stall) begin
          m_busy = 1'b0;
        end
      end else begin
        if (m_redir) m_pc = m_tgt;
        if (ic_rsp_valid) begin
          m_busy = 1'b0;
          m_stale = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; id_stall = 1'b0;
    br_valid = 1'b0; br_target = '0;
    excp_valid = 1'b0; excp_entry = '0;
    ertn_valid = 1'b0; ertn_era = '0;
    ic_req_ready = 1'b1; ic_rsp_valid = 1'b0;

    step(); #1;
    chk1("reset_req_valid", ic_req_valid, 1'b0);
    chk32("reset_req_addr", ic_req_addr, 32'h1C00_0000);
    chk32("reset_fetch_pc", fetch_pc, 32'h1C00_0000);
    chk1("reset_rsp_ready", ic_rsp_ready, 1'b0);
    chk1("reset_fetch_valid", fetch_valid, 1'b0);
    step();
    rst = 1'b0; #1;

    // Sequential fetch, 1-cycle cache: one instruction every 2 cycles
    for (int i = 0; i < 3; i++) begin
      chk1("seq_req_valid", ic_req_valid, 1'b1);
      chk32("seq_req_addr", ic_req_addr, 32'h1C00_0000 + 32'(4 * i));
      step(); #1;
      chk1("seq_fetch_valid", fetch_valid, 1'b1);
      chk32("seq_fetch_pc", fetch_pc, 32'h1C00_0000 + 32'(4 * i));
      chk1("seq_req_idle", ic_req_valid, 1'b0);
      step(); #1;
    end

    // Branch while in RUN
    br_valid = 1'b1; br_target = 32'h1C00_0100; #1;
    chk1("br_clear", if0_if1_clear, 1'b1);
    chk1("br_req_valid", ic_req_valid, 1'b0);
    step(); br_valid = 1'b0; #1;
    chk1("br_next_req_valid", ic_req_valid, 1'b1);
    chk32("br_next_req_addr", ic_req_addr, 32'h1C00_0100);
    step(); #1;
    chk1("br_fetch_valid", fetch_valid, 1'b1);
    chk32("br_fetch_pc", fetch_pc, 32'h1C00_0100);
    lat = 3;
    step();
    step();

    // Redirect while waiting on a slow response
    br_valid = 1'b1; br_target = 32'h1C00_0200; #1;
    chk1("wait_redir_clear", if0_if1_clear, 1'b1);
    chk1("wait_redir_fetch_valid", fetch_valid, 1'b0);
    step(); br_valid = 1'b0; #1;
    chk1("drop_rsp_ready", ic_rsp_ready, 1'b1);
    chk1("drop_req_valid", ic_req_valid, 1'b0);
    step(); #1;
    chk1("drop_rsp_seen", ic_rsp_valid, 1'b1);
    chk1("drop_fetch_valid", fetch_valid, 1'b0);
    step(); lat = 1; #1;
    chk1("drop_next_req_valid", ic_req_valid, 1'b1);
    chk32("drop_next_req_addr", ic_req_addr, 32'h1C00_0200);
    step(); #1;
    chk32("drop_fetch_pc", fetch_pc, 32'h1C00_0200);
    step();

    // Exception and branch together: exception wins
    excp_valid = 1'b1; excp_entry = 32'h1C00_8000;
    br_valid = 1'b1; br_target = 32'h1C00_0300; #1;
    chk1("excp_clear", if0_if1_clear, 1'b1);
    chk1("excp_req_valid", ic_req_valid, 1'b0);
    step(); excp_valid = 1'b0; br_valid = 1'b0; #1;
    chk32("excp_next_req_addr", ic_req_addr, 32'h1C00_8000);
    step(); #1;
    chk32("excp_fetch_pc", fetch_pc, 32'h1C00_8000);
    step();

    // ID stall while a response is waiting
    step(); id_stall = 1'b1; #1;
    chk1("stall_rsp_valid", ic_rsp_valid, 1'b1);
    chk1("stall_rsp_ready", ic_rsp_ready, 1'b0);
    chk1("stall_out", if0_if1_stall, 1'b1);
    chk1("stall_fetch_valid", fetch_valid, 1'b0);
    step(); #1;
    chk1("stall_held_rsp", ic_rsp_valid, 1'b1);
    chk1("stall_held_fetch_valid", fetch_valid, 1'b0);
    step(); id_stall = 1'b0; #1;
    chk1("unstall_fetch_valid", fetch_valid, 1'b1);
    chk32("unstall_fetch_pc", fetch_pc, 32'h1C00_8004);
    chk1("unstall_rsp_ready", ic_rsp_ready, 1'b1);
    step();

    // Reset while dropping, then unaligned branch target
    lat = 3;
    step();
    br_valid = 1'b1; br_target = 32'h1C00_0400; #1;
    chk1("pre_rst_clear", if0_if1_clear, 1'b1);
    step(); br_valid = 1'b0; rst = 1'b1; #1;
    chk1("rst_drop_rsp_ready", ic_rsp_ready, 1'b0);
    chk1("rst_drop_req_valid", ic_req_valid, 1'b0);
    step(); rst = 1'b0; #1;
    chk1("post_rst_req_valid", ic_req_valid, 1'b1);
    chk32("post_rst_req_addr", ic_req_addr, 32'h1C00_0000);
    chk32("post_rst_fetch_pc", fetch_pc, 32'h1C00_0000);
    br_valid = 1'b1; br_target = 32'h1C00_0103; lat = 1; #1;
    chk1("align_clear", if0_if1_clear, 1'b1);
    step(); br_valid = 1'b0; #1;
    chk32("align_req_addr", ic_req_addr, 32'h1C00_0100);
    step(); #1;
    chk1("align_fetch_valid", fetch_valid, 1'b1);
    step();

    // ertn beats branch
    ertn_valid = 1'b1; ertn_era = 32'h1C00_0502;
    br_valid = 1'b1; br_target = 32'h1C00_0600; #1;
    chk1("ertn_clear", if0_if1_clear, 1'b1);
    step(); ertn_valid = 1'b0; br_valid = 1'b0; #1;
    chk32("ertn_req_addr", ic_req_addr, 32'h1C00_0500);

    // Free-running with intermittent stall and cache back-pressure
    for (int i = 0; i < 24; i++) begin
      id_stall = (i % 3 == 1);
      ic_req_ready = (i % 5 != 2);
      step();
    end
    id_stall = 1'b0; ic_req_ready = 1'b1;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
